// File: rtl/accel_pkg.sv
// Shared types for the matrix-engine job scheduler.
package accel_pkg;

  // Scheduler FSM states. Consecutive states differ in one bit.
  // ISSUE and WAIT_DONE share bit 0, so the engine start decode is a single bit.
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_ISSUE     = 2'b01,
    S_WAIT_DONE = 2'b11,
    S_RELEASE   = 2'b10
  } sched_state_t;

  // Default descriptor widths. The scheduler re-declares the entry type from its own parameters.
  localparam int unsigned JOB_K_W   = 4;
  localparam int unsigned JOB_TAG_W = 4;

  // Job descriptor as carried on the control-register side.
  typedef struct packed {
    logic [JOB_K_W-1:0]   k;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;

endpackage

// File: rtl/accel_job_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and an occupancy level.
module accel_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/accel_job_sched.sv
// Job scheduler for the matrix compute engine: queues {k, tag} descriptors,
// runs them one at a time over the level start/done handshake and reports a
// tagged completion plus a one-cycle irq per job.
// Optional watchdog: define ACCEL_SCHED_TIMEOUT_EN to time out WAIT_DONE after TIMEOUT cycles.
module accel_job_sched
  import accel_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned K_W     = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [K_W-1:0]         job_k,
  input  logic [TAG_W-1:0]       job_tag,
  output logic                   eng_start,
  output logic [K_W-1:0]         eng_cfg_k,
  input  logic                   eng_done,
  output logic                   cmp_valid,
  input  logic                   cmp_ready,
  output logic [TAG_W-1:0]       cmp_tag,
  output logic                   cmp_err,
  output logic                   irq,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_level
);

  typedef struct packed {
    logic [K_W-1:0]   k;
    logic [TAG_W-1:0] tag;
  } entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("accel_job_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  sched_state_t     state;
  sched_state_t     state_nxt;
  entry_t           wr_entry;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop_c;
  logic             set_cmp_c;
  logic [TAG_W-1:0] cmp_tag_c;
  logic             cmp_err_c;
  logic             timeout_c;
  logic             err_flag;
  logic [TAG_W-1:0] cur_tag;

  assign wr_entry  = '{k: job_k, tag: job_tag};
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign busy      = (state != S_IDLE) || !empty;

  accel_job_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_c),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (q_level)
  );

`ifdef ACCEL_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;

  // Watchdog: counts cycles spent in WAIT_DONE; a done seen on the last count wins.
  assign timeout_c = (state == S_WAIT_DONE) && !eng_done && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog counter and error flag, both cleared on entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      err_flag <= 1'b0;
    end else if (state == S_ISSUE) begin
      wd_cnt   <= '0;
      err_flag <= 1'b0;
    end else if (state == S_WAIT_DONE) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (timeout_c) err_flag <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err_flag  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pop_c && (head.k != '0)) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (eng_done || timeout_c) state_nxt = S_RELEASE;
      S_RELEASE:   if (!eng_done) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output decode: engine start, queue pop and completion capture.
  always_comb begin
    eng_start = 1'b0;
    pop_c     = 1'b0;
    set_cmp_c = 1'b0;
    cmp_tag_c = cur_tag;
    cmp_err_c = err_flag;
    case (state)
      S_IDLE: begin
        pop_c     = !empty && !cmp_valid;
        set_cmp_c = pop_c && (head.k == '0);
        cmp_tag_c = head.tag;
        cmp_err_c = 1'b1;
      end
      S_ISSUE, S_WAIT_DONE: eng_start = 1'b1;
      S_RELEASE:            set_cmp_c = !eng_done;
      default: ;
    endcase
  end

  // Current job registers; eng_cfg_k only changes when a real job is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cfg_k <= '0;
      cur_tag   <= '0;
    end else if (pop_c) begin
      cur_tag <= head.tag;
      if (head.k != '0) eng_cfg_k <= head.k;
    end
  end

  // Completion record and interrupt; record holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_tag   <= '0;
      cmp_err   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= set_cmp_c;
      if (set_cmp_c) begin
        cmp_valid <= 1'b1;
        cmp_tag   <= cmp_tag_c;
        cmp_err   <= cmp_err_c;
      end else if (cmp_valid && cmp_ready) begin
        cmp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_job_sched.sv
// Self-checking bench for accel_job_sched with a behavioural engine model and
// a descriptor scoreboard. Timeout scenarios run when ACCEL_SCHED_TIMEOUT_EN is defined.
module tb_accel_job_sched;
  import accel_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned K_W   = 4;
  localparam int unsigned TAG_W = 4;
`ifdef ACCEL_SCHED_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 16;
`else
  localparam int unsigned TIMEOUT = 1024;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   job_valid = 1'b0;
  logic                   job_ready;
  logic [K_W-1:0]         job_k = '0;
  logic [TAG_W-1:0]       job_tag = '0;
  logic                   eng_start;
  logic [K_W-1:0]         eng_cfg_k;
  logic                   eng_done = 1'b0;
  logic                   cmp_valid;
  logic                   cmp_ready = 1'b0;
  logic [TAG_W-1:0]       cmp_tag;
  logic                   cmp_err;
  logic                   irq;
  logic                   busy;
  logic [$clog2(DEPTH):0] q_level;

  int n_vec = 0;
  int n_err = 0;

  // Engine model controls and observations.
  bit             eng_stall = 1'b0;
  int             done_dly  = 4;
  int             drop_dly  = 1;
  int             start_cnt = 0;
  int             drop_cnt  = 0;
  int             n_irq     = 0;
  logic [K_W-1:0] eng_k_q[$];
  job_t           exp_q[$];

  accel_job_sched #(
    .DEPTH(DEPTH), .K_W(K_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_k(job_k), .job_tag(job_tag),
    .eng_start(eng_start), .eng_cfg_k(eng_cfg_k), .eng_done(eng_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag), .cmp_err(cmp_err),
    .irq(irq), .busy(busy), .q_level(q_level)
  );

  always #5 clk = ~clk;

  // Engine: raise done done_dly sampled cycles after start rises, drop it drop_dly cycles after start falls.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      eng_done  = 1'b0;
      start_cnt = 0;
      drop_cnt  = 0;
    end else if (eng_start) begin
      if (start_cnt == 0) eng_k_q.push_back(eng_cfg_k);
      start_cnt++;
      drop_cnt = 0;
      if (!eng_stall && start_cnt >= done_dly) eng_done = 1'b1;
    end else begin
      start_cnt = 0;
      if (eng_done) begin
        drop_cnt++;
        if (drop_cnt >= drop_dly) begin
          eng_done = 1'b0;
          drop_cnt = 0;
        end
      end
    end
  end

  // Interrupt pulse counter.
  always @(posedge clk) begin
    #1;
    if (irq === 1'b1) n_irq++;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [K_W-1:0] k, input logic [TAG_W-1:0] tag);
    int n = 0;
    job_k = k;
    job_tag = tag;
    job_valid = 1'b1;
    while (job_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (job_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL push_wait: job_ready=%b required 1 within 200 cycles", job_ready);
      job_valid = 1'b0;
      return;
    end
    tick();
    job_valid = 1'b0;
    exp_q.push_back('{k: k, tag: tag});
  endtask

  // Waits for a completion, captures it, holds it `hold` cycles, then consumes it.
  task automatic wait_cmp(input int hold, output logic [TAG_W-1:0] tag, output logic err,
                          output logic irq_at, output logic irq_after, output bit ok);
    int n = 0;
    ok = 1'b0;
    tag = '0; err = 1'b0; irq_at = 1'b0; irq_after = 1'b0;
    while (cmp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (cmp_valid !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL cmp_wait: cmp_valid=%b required 1 within 300 cycles", cmp_valid);
      return;
    end
    ok = 1'b1;
    tag = cmp_tag; err = cmp_err; irq_at = irq;
    repeat (hold) tick();
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    irq_after = irq;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({job_ready, eng_start, eng_cfg_k, cmp_valid, cmp_tag, cmp_err, irq, busy, q_level} !==
        {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_held: rdy=%b start=%b k=%h cv=%b tag=%h err=%b irq=%b busy=%b lvl=%0d required 1 0 0 0 0 0 0 0 0",
               job_ready, eng_start, eng_cfg_k, cmp_valid, cmp_tag, cmp_err, irq, busy, q_level);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_vec++;
    if ({job_ready, eng_start, eng_cfg_k, cmp_valid, cmp_tag, cmp_err, irq, busy, q_level} !==
        {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_released: rdy=%b start=%b k=%h cv=%b tag=%h err=%b irq=%b busy=%b lvl=%0d required 1 0 0 0 0 0 0 0 0",
               job_ready, eng_start, eng_cfg_k, cmp_valid, cmp_tag, cmp_err, irq, busy, q_level);
    end
  endtask

  task automatic test_single_job();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; int irq0;
    eng_stall = 1'b0; done_dly = 4; drop_dly = 1;
    irq0 = n_irq;
    push_job(4'd2, 4'd5);
    n_vec++;
    if (eng_start !== 1'b0 || q_level !== 3'd1) begin
      n_err++;
      $display("FAIL single_cycle1: start=%b lvl=%0d required start=0 lvl=1", eng_start, q_level);
    end
    tick();
    n_vec++;
    if (eng_start !== 1'b1 || eng_cfg_k !== 4'd2 || q_level !== 3'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_cycle2: start=%b k=%0d lvl=%0d busy=%b required 1 2 0 1",
               eng_start, eng_cfg_k, q_level, busy);
    end
    wait_cmp(0, t, e, ia, iaf, ok);
    if (ok) begin
      void'(exp_q.pop_front());
      n_vec++;
      if (t !== 4'd5 || e !== 1'b0 || ia !== 1'b1 || iaf !== 1'b0) begin
        n_err++;
        $display("FAIL single_cmp: tag=%0d err=%b irq=%b irq_next=%b required 5 0 1 0", t, e, ia, iaf);
      end
    end
    repeat (3) tick();
    n_vec++;
    if (n_irq - irq0 != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_irq_count: pulses=%0d busy=%b required 1 0", n_irq - irq0, busy);
    end
  endtask

  task automatic test_k_zero();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; int s0;
    s0 = eng_k_q.size();
    push_job(4'd0, 4'd3);
    tick();
    n_vec++;
    if (cmp_valid !== 1'b1 || irq !== 1'b1 || eng_start !== 1'b0) begin
      n_err++;
      $display("FAIL kzero_latency: cv=%b irq=%b start=%b required 1 1 0", cmp_valid, irq, eng_start);
    end
    wait_cmp(1, t, e, ia, iaf, ok);
    if (ok) begin
      void'(exp_q.pop_front());
      n_vec++;
      if (t !== 4'd3 || e !== 1'b1 || iaf !== 1'b0) begin
        n_err++;
        $display("FAIL kzero_cmp: tag=%0d err=%b irq_next=%b required 3 1 0", t, e, iaf);
      end
    end
    repeat (4) tick();
    n_vec++;
    if (eng_k_q.size() != s0) begin
      n_err++;
      $display("FAIL kzero_no_start: starts=%0d required 0", eng_k_q.size() - s0);
    end
  endtask

  task automatic test_queue_full();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; job_t x;
    eng_stall = 1'b1; done_dly = 2; drop_dly = 1;
    for (int i = 0; i < 5; i++) push_job(K_W'(i + 1), TAG_W'(i + 1));
    n_vec++;
    if (job_ready !== 1'b0 || q_level !== 3'd4 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL full_state: rdy=%b lvl=%0d busy=%b required 0 4 1", job_ready, q_level, busy);
    end
    job_k = 4'hF; job_tag = 4'hF; job_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (job_ready !== 1'b0 || q_level !== 3'd4) begin
        n_err++;
        $display("FAIL full_refuse: cycle=%0d rdy=%b lvl=%0d required 0 4", i, job_ready, q_level);
      end
    end
    job_valid = 1'b0;
    eng_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cmp(0, t, e, ia, iaf, ok);
      if (ok && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_vec++;
        if (t !== x.tag || e !== 1'b0) begin
          n_err++;
          $display("FAIL full_order: idx=%0d tag=%0d err=%b required %0d 0", i, t, e, x.tag);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; int n;
    eng_stall = 1'b0; done_dly = 3; drop_dly = 1;
    push_job(4'd5, 4'd7);
    push_job(4'd6, 4'd9);
    n = 0;
    while (cmp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    n_vec++;
    if (cmp_valid !== 1'b1 || cmp_tag !== 4'd7) begin
      n_err++;
      $display("FAIL bp_first: cv=%b tag=%0d required 1 7", cmp_valid, cmp_tag);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (cmp_valid !== 1'b1 || cmp_tag !== 4'd7 || eng_start !== 1'b0 || q_level !== 3'd1) begin
        n_err++;
        $display("FAIL bp_hold: cycle=%0d cv=%b tag=%0d start=%b lvl=%0d required 1 7 0 1",
                 i, cmp_valid, cmp_tag, eng_start, q_level);
      end
    end
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    void'(exp_q.pop_front());
    n_vec++;
    if (cmp_valid !== 1'b0 || eng_start !== 1'b0 || q_level !== 3'd1) begin
      n_err++;
      $display("FAIL bp_release: cv=%b start=%b lvl=%0d required 0 0 1", cmp_valid, eng_start, q_level);
    end
    tick();
    n_vec++;
    if (eng_start !== 1'b1 || q_level !== 3'd0 || eng_cfg_k !== 4'd6) begin
      n_err++;
      $display("FAIL bp_back_to_back: start=%b lvl=%0d k=%0d required 1 0 6", eng_start, q_level, eng_cfg_k);
    end
    wait_cmp(0, t, e, ia, iaf, ok);
    if (ok) begin
      void'(exp_q.pop_front());
      n_vec++;
      if (t !== 4'd9 || e !== 1'b0) begin
        n_err++;
        $display("FAIL bp_second: tag=%0d err=%b required 9 0", t, e);
      end
    end
  endtask

  task automatic test_random();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; job_t x;
    logic [K_W-1:0] k;
    logic [K_W-1:0] kq[$];
    int irq0, nb;
    eng_stall = 1'b0;
    repeat (3) tick();
    eng_k_q.delete();
    for (int it = 0; it < 12; it++) begin
      done_dly = $urandom_range(1, 8);
      drop_dly = $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      irq0 = n_irq;
      for (int j = 0; j < nb; j++) begin
        k = ($urandom_range(0, 4) == 0) ? K_W'(0) : K_W'($urandom_range(1, 15));
        push_job(k, TAG_W'($urandom));
        if (k != '0) kq.push_back(k);
      end
      for (int j = 0; j < nb; j++) begin
        wait_cmp($urandom_range(0, 3), t, e, ia, iaf, ok);
        if (ok && exp_q.size() > 0) begin
          x = exp_q.pop_front();
          n_vec++;
          if (t !== x.tag || e !== (x.k == '0)) begin
            n_err++;
            $display("FAIL rand_cmp: iter=%0d tag=%0d err=%b required %0d %b", it, t, e, x.tag, (x.k == '0));
          end
        end
      end
      repeat (3) tick();
      n_vec++;
      if (n_irq - irq0 != nb) begin
        n_err++;
        $display("FAIL rand_irq: iter=%0d pulses=%0d required %0d", it, n_irq - irq0, nb);
      end
    end
    n_vec++;
    if (eng_k_q.size() != kq.size()) begin
      n_err++;
      $display("FAIL rand_starts: starts=%0d required %0d", eng_k_q.size(), kq.size());
    end else begin
      for (int i = 0; i < kq.size(); i++) begin
        n_vec++;
        if (eng_k_q[i] !== kq[i]) begin
          n_err++;
          $display("FAIL rand_cfg_k: idx=%0d k=%0d required %0d", i, eng_k_q[i], kq[i]);
        end
      end
    end
  endtask

`ifdef ACCEL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok; int n_hi, n;
    int dly[3];
    logic exp_err[3];
    dly[0] = 0;           exp_err[0] = 1'b1;
    dly[1] = TIMEOUT + 1; exp_err[1] = 1'b0;
    dly[2] = TIMEOUT + 2; exp_err[2] = 1'b1;
    drop_dly = 1;
    for (int c = 0; c < 3; c++) begin
      eng_stall = (c == 0);
      done_dly = dly[c];
      push_job(4'd1, TAG_W'(10 + c));
      n_hi = 0; n = 0;
      while (n < 100) begin
        tick();
        n++;
        if (eng_start === 1'b1) n_hi++;
        else if (n_hi > 0) break;
      end
      n_vec++;
      if (n_hi != TIMEOUT + 1) begin
        n_err++;
        $display("FAIL tmo_start_len: case=%0d high=%0d required %0d", c, n_hi, TIMEOUT + 1);
      end
      wait_cmp(0, t, e, ia, iaf, ok);
      if (ok) begin
        void'(exp_q.pop_front());
        n_vec++;
        if (t !== TAG_W'(10 + c) || e !== exp_err[c]) begin
          n_err++;
          $display("FAIL tmo_cmp: case=%0d tag=%0d err=%b required %0d %b", c, t, e, 10 + c, exp_err[c]);
        end
      end
      repeat (3) tick();
    end
    eng_stall = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    logic [TAG_W-1:0] t; logic e, ia, iaf; bit ok;
    eng_stall = 1'b1; done_dly = 2; drop_dly = 1;
    push_job(4'd3, 4'd1);
    push_job(4'd4, 4'd2);
    tick();
    n_vec++;
    if (eng_start !== 1'b1 || q_level !== 3'd1) begin
      n_err++;
      $display("FAIL rst_pre: start=%b lvl=%0d required 1 1", eng_start, q_level);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (eng_start !== 1'b0 || q_level !== 3'd0 || cmp_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: start=%b lvl=%0d cv=%b busy=%b rdy=%b required 0 0 0 0 1",
               eng_start, q_level, cmp_valid, busy, job_ready);
    end
    tick();
    rst_n = 1'b1;
    eng_stall = 1'b0;
    exp_q.delete();
    tick();
    push_job(4'd7, 4'hC);
    wait_cmp(0, t, e, ia, iaf, ok);
    if (ok) begin
      void'(exp_q.pop_front());
      n_vec++;
      if (t !== 4'hC || e !== 1'b0) begin
        n_err++;
        $display("FAIL rst_after_job: tag=%0d err=%b required 12 0", t, e);
      end
    end
    repeat (20) tick();
    n_vec++;
    if (cmp_valid !== 1'b0 || q_level !== 3'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flushed: cv=%b lvl=%0d busy=%b required 0 0 0", cmp_valid, q_level, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_k_zero();
    test_queue_full();
    test_backpressure();
    test_random();
`ifdef ACCEL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
